vslc_timer_cmd: RTL and testbench
=================================

Name: vslc_timer_cmd

Overview:
- Upstream command front-end for the bank of VSLC two-phase timers.
- Accepts a byte stream over a valid/ready handshake and holds the per-timer period_a/period_b registers.
- Generates the one-cycle set/reset pulses the timers edge-detect.
- Sits between the host/serial byte source and NUM_TIMERS timer instances.

Parameters:
- NUM_TIMERS, 4: timers served; 1..32.
- PERIOD_W, 10: period width; 9..16.

Ports:
- clk  in  1  single clock, all logic posedge.
- rst  in  1  synchronous reset, active-high.
- cmd_data  in  8  command/payload byte.
- cmd_valid  in  1  cmd_data valid.
- cmd_ready  out  1  byte accepted when cmd_valid && cmd_ready at posedge.
- timer_period_a  out  NUM_TIMERS*PERIOD_W  flat; timer i at [i*PERIOD_W +: PERIOD_W].
- timer_period_b  out  NUM_TIMERS*PERIOD_W  same packing.
- timer_set  out  NUM_TIMERS  one-cycle set pulse per timer.
- timer_reset  out  NUM_TIMERS  one-cycle reset pulse per timer.
- err  out  1  sticky error flag.

Behaviour:
- Reset (rst high at posedge): FSM=IDLE; all periods 0; timer_set/timer_reset 0; err 0; staging cleared. cmd_ready is 0 during the reset cycle and 1 from the first cycle after.
- Command byte layout: op=[7:5], idx=[4:0].
  - 000 NOP.
  - 001 WR_A and 010 WR_B: each is followed by 2 payload bytes, LO=bits[7:0] then HI=bits[PERIOD_W-1:8]. HI bits above PERIOD_W-9 are ignored.
  - 011 START: pulse timer_set[idx].
  - 100 STOP: pulse timer_reset[idx].
  - 101 RESTART: pulse reset, then set.
  - 110 illegal.
  - 111 CLR_ERR: clears err. idx is ignored.
- FSM states: IDLE, PAY_LO, PAY_HI, PULSE, GAP, PULSE2, GAP2.
  - IDLE: accept an opcode. WR_A/WR_B latch op+idx and go to PAY_LO. START/STOP/RESTART go to PULSE. NOP, CLR_ERR and errors stay in IDLE.
  - PAY_LO: accept LO into staging, go to PAY_HI.
  - PAY_HI: accept HI. On the same posedge the full PERIOD_W value is committed atomically into period_a[idx] or period_b[idx]. Return to IDLE. The period output never shows a half-written value.
  - PULSE: drive the selected line high for exactly this cycle, then GAP.
  - GAP: all pulse lines low for one cycle. Next state is PULSE2 for RESTART, otherwise IDLE.
  - PULSE2: timer_set[idx] high for one cycle, then GAP2.
  - GAP2: lines low, then IDLE.
- cmd_ready=1 in IDLE/PAY_LO/PAY_HI; 0 in PULSE/GAP/PULSE2/GAP2.
- Timing:
  - START/STOP accepted at edge N → pulse high in cycle N+1 → cmd_ready back high in cycle N+3.
  - RESTART accepted at N → reset high in N+1 → set high in N+3 → ready in N+5.
  - Consequence: every pulse is preceded and followed by at least one low cycle, which satisfies the timer's rising-edge detection.
- Pulse outputs are registered. At most one bit of timer_set|timer_reset is high in any cycle.
- Error handling:
  - Illegal op 110, or idx ≥ NUM_TIMERS on ops 001–101, sets err. The byte is consumed and the FSM stays in IDLE; no payload is expected and no pulse or write occurs.
  - err holds until CLR_ERR or rst.
  - CLR_ERR and a new error cannot occur in the same byte.
- Payload bytes are never decoded as opcodes. Gaps in cmd_valid between payload bytes are allowed with no timeout.
- rst mid-payload or mid-pulse: the partial command is discarded, any in-flight pulse is dropped to 0 on that posedge, and periods return to 0.
- Period writes to a running timer take effect immediately on the output; the block does not synchronise them to the timer phase.

Test Plan:
- Reset: after rst, all periods=0, set/reset=0, err=0, cmd_ready=1. Send WR_A idx1 with bytes 0x21, 0x34, 0x02 → period_a[1]=0x234; period_a[1] stays 0 until the HI accept edge; other timers unchanged.
- START idx2 accepted at edge N → timer_set=4'b0100 in cycle N+1 only. cmd_ready=0 in N+1..N+2 and 1 in N+3. Back-to-back START idx2 gives two pulses separated by ≥2 low cycles.
- RESTART idx0 → timer_reset[0] high in N+1; both lines low in N+2; timer_set[0] high in N+3; ready in N+5. Driving a real timer instance shows timer_enabled high from N+4 onward.
- Errors: byte 0xC0 (op 110) → err=1, next byte decoded as an opcode. 0x25 (WR_A idx5, NUM_TIMERS=4) → err=1, no write, next byte is an opcode. 0xE0 → err=0.
- WR_B idx3 with cmd_valid toggling between bytes; HI=0xFF with PERIOD_W=10 → period_b[3][9:8]=2'b11 and upper bits ignored.
- Assert rst after the LO byte of WR_A, then send HI-looking byte 0x03 → treated as opcode 000 idx3 (NOP). Periods remain 0 and err=0.

Source files
------------

// File: rtl/vslc_timer_cmd.sv
// Command front-end for the VSLC two-phase timer bank: decodes a byte stream into
// per-timer period registers and one-cycle set/reset pulses.
module vslc_timer_cmd #(
    parameter int NUM_TIMERS = 4,
    parameter int PERIOD_W   = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [7:0]                     cmd_data,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    output logic [NUM_TIMERS*PERIOD_W-1:0] timer_period_a,
    output logic [NUM_TIMERS*PERIOD_W-1:0] timer_period_b,
    output logic [NUM_TIMERS-1:0]          timer_set,
    output logic [NUM_TIMERS-1:0]          timer_reset,
    output logic                           err,
    output logic [2:0]                     dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PAY_LO = 3'd1,
        S_PAY_HI = 3'd2,
        S_PULSE  = 3'd3,
        S_GAP    = 3'd4,
        S_PULSE2 = 3'd5,
        S_GAP2   = 3'd6
    } state_t;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_WR_A    = 3'd1;
    localparam logic [2:0] OP_WR_B    = 3'd2;
    localparam logic [2:0] OP_START   = 3'd3;
    localparam logic [2:0] OP_STOP    = 3'd4;
    localparam logic [2:0] OP_RESTART = 3'd5;
    localparam logic [2:0] OP_ILLEGAL = 3'd6;
    localparam logic [2:0] OP_CLR_ERR = 3'd7;

    state_t                state_q;
    logic [2:0]            op_q;
    logic [4:0]            idx_q;
    logic [7:0]            lo_q;
    logic [PERIOD_W-1:0]   period_a_q [NUM_TIMERS];
    logic [PERIOD_W-1:0]   period_b_q [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] set_q;
    logic [NUM_TIMERS-1:0] reset_q;
    logic                  err_q;

    logic                  accept;
    logic [2:0]            cmd_op;
    logic [4:0]            cmd_idx;
    logic                  idx_ok;
    logic [PERIOD_W-1:0]   wr_value;

    // Handshake: a byte transfers on a posedge where cmd_valid and cmd_ready are
    // both high; cmd_ready depends only on state (and rst), never on cmd_valid.
    assign cmd_ready = ~rst & ((state_q == S_IDLE) | (state_q == S_PAY_LO) |
                               (state_q == S_PAY_HI));
    assign accept    = cmd_valid & cmd_ready;
    assign cmd_op    = cmd_data[7:5];
    assign cmd_idx   = cmd_data[4:0];
    assign idx_ok    = ({1'b0, cmd_idx} < 6'(NUM_TIMERS));
    // HI byte bits above the period width are dropped here.
    assign wr_value  = {cmd_data[PERIOD_W-9:0], lo_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            idx_q   <= '0;
            lo_q    <= '0;
            set_q   <= '0;
            reset_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < NUM_TIMERS; i++) begin
                period_a_q[i] <= '0;
                period_b_q[i] <= '0;
            end
        end else begin
            set_q   <= '0;
            reset_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        case (cmd_op)
                            OP_WR_A, OP_WR_B: begin
                                if (idx_ok) begin
                                    op_q    <= cmd_op;
                                    idx_q   <= cmd_idx;
                                    state_q <= S_PAY_LO;
                                end else begin
                                    err_q <= 1'b1;
                                end
                            end
                            OP_START, OP_STOP, OP_RESTART: begin
                                if (idx_ok) begin
                                    op_q    <= cmd_op;
                                    idx_q   <= cmd_idx;
                                    state_q <= S_PULSE;
                                    for (int i = 0; i < NUM_TIMERS; i++) begin
                                        if (cmd_idx == 5'(i)) begin
                                            if (cmd_op == OP_START) set_q[i] <= 1'b1;
                                            else                    reset_q[i] <= 1'b1;
                                        end
                                    end
                                end else begin
                                    err_q <= 1'b1;
                                end
                            end
                            OP_ILLEGAL: err_q <= 1'b1;
                            OP_CLR_ERR: err_q <= 1'b0;
                            default: ;
                        endcase
                    end
                end
                S_PAY_LO: begin
                    if (accept) begin
                        lo_q    <= cmd_data;
                        state_q <= S_PAY_HI;
                    end
                end
                S_PAY_HI: begin
                    if (accept) begin
                        for (int i = 0; i < NUM_TIMERS; i++) begin
                            if (idx_q == 5'(i)) begin
                                if (op_q == OP_WR_A) period_a_q[i] <= wr_value;
                                else                 period_b_q[i] <= wr_value;
                            end
                        end
                        state_q <= S_IDLE;
                    end
                end
                S_PULSE: state_q <= S_GAP;
                S_GAP: begin
                    if (op_q == OP_RESTART) begin
                        state_q <= S_PULSE2;
                        for (int i = 0; i < NUM_TIMERS; i++) begin
                            if (idx_q == 5'(i)) set_q[i] <= 1'b1;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_PULSE2: state_q <= S_GAP2;
                S_GAP2:   state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_flat
        assign timer_period_a[g*PERIOD_W +: PERIOD_W] = period_a_q[g];
        assign timer_period_b[g*PERIOD_W +: PERIOD_W] = period_b_q[g];
    end

    assign timer_set   = set_q;
    assign timer_reset = reset_q;
    assign err         = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_vslc_timer_cmd.sv
// Directed bench for vslc_timer_cmd (NUM_TIMERS=4, PERIOD_W=10).
module tb_vslc_timer_cmd;
  localparam int NT = 4;
  localparam int PW = 10;

  logic            clk;
  logic            rst;
  logic [7:0]      cmd_data;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [NT*PW-1:0] timer_period_a;
  logic [NT*PW-1:0] timer_period_b;
  logic [NT-1:0]   timer_set;
  logic [NT-1:0]   timer_reset;
  logic            err;
  logic [2:0]      dbg_state;

  int n_checks;
  int n_fail;
  logic hist_en;
  logic [NT-1:0] hist_q[$];

  vslc_timer_cmd #(.NUM_TIMERS(NT), .PERIOD_W(PW)) dut (
    .clk(clk), .rst(rst), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .timer_period_a(timer_period_a),
    .timer_period_b(timer_period_b), .timer_set(timer_set),
    .timer_reset(timer_reset), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // continuous monitor: never more than one pulse line high
  always @(negedge clk) begin
    if (!rst) begin
      n_checks++;
      if ($countones({timer_set, timer_reset}) > 1) begin
        n_fail++;
        $display("FAIL onehot_pulse: set=%b reset=%b, at most one bit allowed", timer_set, timer_reset);
      end
    end
    if (hist_en) hist_q.push_back(timer_set);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // driver: returns #1 after the accepting edge (cycle N+1)
  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    cmd_data  = b;
    cmd_valid = 1'b1;
    while (!cmd_ready && waited < 20) begin
      step(1);
      waited++;
    end
    if (!cmd_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: byte=%h cmd_ready=%b after %0d cycles, required 1", b, cmd_ready, waited);
    end
    step(1);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_data = 8'h00;
    step(2);
    n_checks++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low: got %b, required 0", cmd_ready); end
    rst = 1'b0;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_high: got %b, required 1", cmd_ready); end
    n_checks++;
    if (timer_period_a !== '0 || timer_period_b !== '0) begin
      n_fail++; $display("FAIL reset_periods: a=%h b=%h, required 0", timer_period_a, timer_period_b);
    end
    n_checks++;
    if (timer_set !== '0 || timer_reset !== '0 || err !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: set=%b reset=%b err=%b, required 0", timer_set, timer_reset, err);
    end
  endtask

  task automatic test_write_a;
    logic [NT*PW-1:0] exp_a;
    exp_a = '0;
    send_byte(8'h21);
    send_byte(8'h34);
    n_checks++;
    if (timer_period_a !== '0) begin n_fail++; $display("FAIL wr_a_before_hi: got %h, required 0", timer_period_a); end
    send_byte(8'h02);
    exp_a[1*PW +: PW] = 10'h234;
    n_checks++;
    if (timer_period_a !== exp_a) begin n_fail++; $display("FAIL wr_a_commit: got %h, required %h", timer_period_a, exp_a); end
    n_checks++;
    if (timer_period_b !== '0) begin n_fail++; $display("FAIL wr_a_b_untouched: got %h, required 0", timer_period_b); end
  endtask

  task automatic test_start_stop;
    send_byte(8'h62);
    n_checks++;
    if (timer_set !== 4'b0100 || timer_reset !== 4'b0000 || cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL start_n1: set=%b reset=%b ready=%b, required 0100/0000/0", timer_set, timer_reset, cmd_ready);
    end
    step(1);
    n_checks++;
    if (timer_set !== 4'b0000 || cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL start_n2: set=%b ready=%b, required 0000/0", timer_set, cmd_ready);
    end
    step(1);
    n_checks++;
    if (cmd_ready !== 1'b1 || timer_set !== 4'b0000) begin
      n_fail++; $display("FAIL start_n3: ready=%b set=%b, required 1/0000", cmd_ready, timer_set);
    end
    send_byte(8'h83);
    n_checks++;
    if (timer_reset !== 4'b1000 || timer_set !== 4'b0000) begin
      n_fail++; $display("FAIL stop_n1: reset=%b set=%b, required 1000/0000", timer_reset, timer_set);
    end
    step(2);
  endtask

  task automatic test_back_to_back;
    int ones;
    int last;
    hist_q.delete();
    hist_en = 1'b1;
    send_byte(8'h62);
    send_byte(8'h62);
    step(3);
    hist_en = 1'b0;
    ones = 0;
    last = -10;
    for (int i = 0; i < hist_q.size(); i++) begin
      if (hist_q[i] != '0) begin
        ones++;
        n_checks++;
        if (hist_q[i] !== 4'b0100 || (i - last) < 3) begin
          n_fail++; $display("FAIL b2b_pulse: pos=%0d value=%b gap=%0d, required 0100 with >=2 low cycles between", i, hist_q[i], i - last - 1);
        end
        last = i;
      end
    end
    n_checks++;
    if (ones != 2) begin n_fail++; $display("FAIL b2b_count: got %0d pulses, required 2", ones); end
  endtask

  task automatic test_restart;
    send_byte(8'hA0);
    n_checks++;
    if (timer_reset !== 4'b0001 || timer_set !== 4'b0000) begin
      n_fail++; $display("FAIL restart_n1: reset=%b set=%b, required 0001/0000", timer_reset, timer_set);
    end
    step(1);
    n_checks++;
    if (timer_reset !== 4'b0000 || timer_set !== 4'b0000 || cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL restart_n2: reset=%b set=%b ready=%b, required 0000/0000/0", timer_reset, timer_set, cmd_ready);
    end
    step(1);
    n_checks++;
    if (timer_set !== 4'b0001 || timer_reset !== 4'b0000 || cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL restart_n3: set=%b reset=%b ready=%b, required 0001/0000/0", timer_set, timer_reset, cmd_ready);
    end
    step(1);
    n_checks++;
    if (timer_set !== 4'b0000 || cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL restart_n4: set=%b ready=%b, required 0000/0", timer_set, cmd_ready);
    end
    step(1);
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL restart_n5: ready=%b, required 1", cmd_ready); end
  endtask

  task automatic test_errors;
    logic [NT*PW-1:0] exp_a;
    exp_a = '0;
    exp_a[1*PW +: PW] = 10'h234;
    send_byte(8'hC0);
    n_checks++;
    if (err !== 1'b1 || cmd_ready !== 1'b1 || dbg_state !== 3'd0) begin
      n_fail++; $display("FAIL err_illegal: err=%b ready=%b state=%0d, required 1/1/0", err, cmd_ready, dbg_state);
    end
    send_byte(8'h62);
    n_checks++;
    if (timer_set !== 4'b0100) begin n_fail++; $display("FAIL err_next_opcode: set=%b, required 0100", timer_set); end
    step(2);
    send_byte(8'hE0);
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL clr_err: err=%b, required 0", err); end
    send_byte(8'h25);
    n_checks++;
    if (err !== 1'b1 || dbg_state !== 3'd0) begin
      n_fail++; $display("FAIL err_bad_idx: err=%b state=%0d, required 1/0", err, dbg_state);
    end
    send_byte(8'h62);
    n_checks++;
    if (timer_set !== 4'b0100) begin n_fail++; $display("FAIL err_idx_next_opcode: set=%b, required 0100", timer_set); end
    step(2);
    send_byte(8'h7F);
    n_checks++;
    if (err !== 1'b1 || timer_set !== 4'b0000 || timer_reset !== 4'b0000 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL err_start_idx31: err=%b set=%b reset=%b ready=%b, required 1/0000/0000/1", err, timer_set, timer_reset, cmd_ready);
    end
    n_checks++;
    if (timer_period_a !== exp_a || timer_period_b !== '0) begin
      n_fail++; $display("FAIL err_no_write: a=%h b=%h, required %h/0", timer_period_a, timer_period_b, exp_a);
    end
    send_byte(8'hFF);
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL clr_err_idx_ignored: err=%b, required 0", err); end
  endtask

  task automatic test_wr_b_gaps;
    logic [NT*PW-1:0] exp_b;
    exp_b = '0;
    send_byte(8'h43);
    step(3);
    n_checks++;
    if (dbg_state !== 3'd1 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL wr_b_wait_lo: state=%0d ready=%b, required 1/1", dbg_state, cmd_ready);
    end
    send_byte(8'h5A);
    step(2);
    n_checks++;
    if (timer_period_b !== '0) begin n_fail++; $display("FAIL wr_b_before_hi: got %h, required 0", timer_period_b); end
    send_byte(8'hFF);
    exp_b[3*PW +: PW] = 10'h35A;
    n_checks++;
    if (timer_period_b !== exp_b) begin n_fail++; $display("FAIL wr_b_commit: got %h, required %h", timer_period_b, exp_b); end
  endtask

  task automatic test_reset_mid_payload;
    send_byte(8'h21);
    send_byte(8'h77);
    rst = 1'b1;
    step(1);
    n_checks++;
    if (cmd_ready !== 1'b0 || timer_period_a !== '0 || timer_period_b !== '0) begin
      n_fail++; $display("FAIL rst_mid_payload: ready=%b a=%h b=%h, required 0/0/0", cmd_ready, timer_period_a, timer_period_b);
    end
    rst = 1'b0;
    send_byte(8'h03);
    step(1);
    n_checks++;
    if (timer_period_a !== '0 || err !== 1'b0 || cmd_ready !== 1'b1 || dbg_state !== 3'd0) begin
      n_fail++; $display("FAIL rst_then_nop: a=%h err=%b ready=%b state=%0d, required 0/0/1/0", timer_period_a, err, cmd_ready, dbg_state);
    end
  endtask

  task automatic test_reset_mid_pulse;
    int seen;
    send_byte(8'hA1);
    rst = 1'b1;
    step(1);
    n_checks++;
    if (timer_reset !== '0 || timer_set !== '0) begin
      n_fail++; $display("FAIL rst_mid_pulse: reset=%b set=%b, required 0/0", timer_reset, timer_set);
    end
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (timer_set != '0) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL rst_drops_restart: %0d set pulses seen, required 0", seen); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    hist_en = 1'b0;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_data = 8'h00;
    test_reset();
    test_write_a();
    test_start_stop();
    test_back_to_back();
    test_restart();
    test_errors();
    test_wr_b_gaps();
    test_reset_mid_payload();
    test_reset_mid_pulse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
